mvm_bn_res_relu_stream: RTL

//  Streaming post-processor after the HBM MVM core: per output pixel applies per-channel BN
//  (scale+bias), optional residual add, optional ReLU, requantises to DAT_DW, on TOUT lanes/beat.

---
 rtl/mvm_post_pkg.sv | 34 +++
 rtl/mvm_bn_res_relu_stream_if.sv | 11 +
 rtl/mvm_post_lane.sv | 61 ++++++
 rtl/mvm_bn_res_relu_stream.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mvm_post_pkg.sv
// Shared types and constants for the MVM BN / residual / ReLU post-processor.
package mvm_post_pkg;

    localparam int unsigned DAT_DW = 16;
    localparam int unsigned BN_DW  = 16;
    // Wide enough for (x*w) plus a bias or residual shifted left by up to 31.
    localparam int unsigned ACC_DW = DAT_DW + BN_DW + 32;

    typedef logic signed [DAT_DW-1:0] dat_t;
    typedef logic signed [BN_DW-1:0]  bn_t;
    typedef logic signed [ACC_DW-1:0] acc_t;

    // One lane of a BN table row: bias in the upper half, weight in the lower half.
    typedef struct packed {
        bn_t bias;
        bn_t weight;
    } bn_entry_t;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    localparam acc_t SAT_MAX = acc_t'({1'b0, {(DAT_DW-1){1'b1}}});
    localparam acc_t SAT_MIN = ~SAT_MAX;

    // Clamp a wide signed value into the DAT_DW signed range.
    function automatic dat_t sat_dat(input acc_t v);
        if (v > SAT_MAX) begin
            return {1'b0, {(DAT_DW-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, {(DAT_DW-1){1'b0}}};
        end
        return v[DAT_DW-1:0];
    endfunction

endpackage

// File: rtl/mvm_bn_res_relu_stream_if.sv
// Valid/ready data stream used for the MVM input, the residual input and the result.
interface mvm_bn_res_relu_stream_if #(
    parameter int unsigned W = 512
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mvm_post_lane.sv
// One output lane: S2 (BN scale + bias) and S3 (residual, shift, saturate, ReLU).
module mvm_post_lane
    import mvm_post_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    input  dat_t       x,
    input  dat_t       r,
    input  bn_entry_t  bn,
    input  logic       bn_en,
    input  logic       res_en,
    input  logic       relu_en,
    input  logic [4:0] wt_shift,
    input  logic [4:0] bias_lsh,
    input  logic [4:0] res_lsh,
    input  logic [4:0] out_shift,
    output dat_t       z
);
    acc_t prod, y_d, y_q, z_sum, z_shr;
    dat_t r_q, z_d, z_q;

    // S2: scale by the BN weight, then add the aligned bias; bypass passes x through
    always_comb begin
        prod = acc_t'(x) * acc_t'(bn.weight);
        if (bn_en) begin
            y_d = (prod >>> wt_shift) + (acc_t'(bn.bias) <<< bias_lsh);
        end else begin
            y_d = acc_t'(x);
        end
    end

    // S3: optional residual add, requantise, saturate and optional ReLU
    always_comb begin
        z_sum = y_q;
        if (res_en) begin
            z_sum = y_q + (acc_t'(r_q) <<< res_lsh);
        end
        z_shr = z_sum >>> out_shift;
        z_d   = sat_dat(z_shr);
        if (relu_en && z_d[DAT_DW-1]) begin
            z_d = '0;
        end
    end

    // S2/S3 registers; frozen together with the rest of the pipe on a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
            r_q <= '0;
            z_q <= '0;
        end else if (adv) begin
            y_q <= y_d;
            r_q <= r;
            z_q <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: rtl/mvm_bn_res_relu_stream.sv
// Streaming post-processor after the MVM core: job FSM, beat counters, BN table,
// MVM/residual join and a 3-stage valid pipe over TOUT arithmetic lanes.
module mvm_bn_res_relu_stream
    import mvm_post_pkg::*;
#(
    parameter  int unsigned TOUT    = 32,
    parameter  int unsigned MAX_CHG = 64,
    parameter  int unsigned PIX_DW  = 20,
    localparam int unsigned CHG_AW  = $clog2(MAX_CHG),
    localparam int unsigned CHG_W   = CHG_AW + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic [PIX_DW-1:0]         cfg_pixels,
    input  logic [CHG_W-1:0]          cfg_chg,
    input  logic                      cfg_bn_en,
    input  logic                      cfg_res_en,
    input  logic                      cfg_relu_en,
    input  logic [4:0]                cfg_wt_shift,
    input  logic [4:0]                cfg_bias_lsh,
    input  logic [4:0]                cfg_res_lsh,
    input  logic [4:0]                cfg_out_shift,
    input  logic                      bn_wr_en,
    input  logic [CHG_AW-1:0]         bn_wr_addr,
    input  logic [TOUT*2*BN_DW-1:0]   bn_wr_data,
    mvm_bn_res_relu_stream_if.slave   mvm,
    mvm_bn_res_relu_stream_if.slave   res,
    mvm_bn_res_relu_stream_if.master  result,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);
    state_t                  state_q;
    logic [PIX_DW-1:0]       pix_q, pixels_q;
    logic [CHG_W-1:0]        grp_q, chg_q;
    logic                    zero_q, bn_en_q, res_en_q, relu_en_q, busy_q, done_q;
    logic [4:0]              wt_shift_q, bias_lsh_q, res_lsh_q, out_shift_q;
    logic                    s1_valid_q, s2_valid_q, s3_valid_q;
    logic                    s1_last_q, s2_last_q, s3_last_q;
    logic [TOUT*DAT_DW-1:0]  s1_x_q, s1_r_q, z_all;
    logic [TOUT*2*BN_DW-1:0] bn_ram [MAX_CHG];
    logic [TOUT*2*BN_DW-1:0] bn_rd_q;
    logic                    run_act, pipe_adv, accept, last_beat;

    // Join: an MVM beat and its residual are only ever consumed in the same cycle
    always_comb begin
        run_act   = (state_q == StRun) && !zero_q;
        pipe_adv  = !s3_valid_q || result.ready;
        mvm.ready = run_act && pipe_adv && (res.valid || !res_en_q);
        res.ready = run_act && pipe_adv && res_en_q && mvm.valid && res.valid;
        accept    = mvm.valid && mvm.ready;
        last_beat = (pix_q == pixels_q - PIX_DW'(1)) && (grp_q == chg_q - CHG_W'(1));
    end

    // Job FSM: latches the configuration, walks pixel (inner) x group (outer), signals done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pix_q       <= '0;
            grp_q       <= '0;
            pixels_q    <= '0;
            chg_q       <= '0;
            zero_q      <= 1'b0;
            bn_en_q     <= 1'b0;
            res_en_q    <= 1'b0;
            relu_en_q   <= 1'b0;
            wt_shift_q  <= '0;
            bias_lsh_q  <= '0;
            res_lsh_q   <= '0;
            out_shift_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A start coinciding with the done pulse is dropped
                    if (cfg_start && !done_q) begin
                        pixels_q    <= cfg_pixels;
                        chg_q       <= cfg_chg;
                        zero_q      <= (cfg_pixels == '0) || (cfg_chg == '0);
                        bn_en_q     <= cfg_bn_en;
                        res_en_q    <= cfg_res_en;
                        relu_en_q   <= cfg_relu_en;
                        wt_shift_q  <= cfg_wt_shift;
                        bias_lsh_q  <= cfg_bias_lsh;
                        res_lsh_q   <= cfg_res_lsh;
                        out_shift_q <= cfg_out_shift;
                        pix_q       <= '0;
                        grp_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StRun;
                    end
                end
                StRun: begin
                    if (zero_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (accept) begin
                        if (last_beat) begin
                            state_q <= StDrain;
                        end else if (pix_q == pixels_q - PIX_DW'(1)) begin
                            pix_q <= '0;
                            grp_q <= grp_q + CHG_W'(1);
                        end else begin
                            pix_q <= pix_q + PIX_DW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (result.valid && result.ready && s3_last_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Valid/last pipe: all stages advance together or hold together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            s3_last_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_r_q     <= '0;
        end else if (pipe_adv) begin
            s1_valid_q <= accept;
            s1_last_q  <= accept && last_beat;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s3_valid_q <= s2_valid_q;
            s3_last_q  <= s2_last_q;
            s1_x_q     <= mvm.data;
            s1_r_q     <= res.data;
        end
    end

    // BN table: writes only while idle, synchronous read of the current group in S1
    always_ff @(posedge clk) begin
        if (bn_wr_en && !busy_q) begin
            bn_ram[bn_wr_addr] <= bn_wr_data;
        end
        if (pipe_adv) begin
            bn_rd_q <= bn_ram[grp_q[CHG_AW-1:0]];
        end
    end

    for (genvar i = 0; i < TOUT; i++) begin : g_lane
        mvm_post_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (pipe_adv),
            .x         (s1_x_q[i*DAT_DW +: DAT_DW]),
            .r         (s1_r_q[i*DAT_DW +: DAT_DW]),
            .bn        (bn_rd_q[i*2*BN_DW +: 2*BN_DW]),
            .bn_en     (bn_en_q),
            .res_en    (res_en_q),
            .relu_en   (relu_en_q),
            .wt_shift  (wt_shift_q),
            .bias_lsh  (bias_lsh_q),
            .res_lsh   (res_lsh_q),
            .out_shift (out_shift_q),
            .z         (z_all[i*DAT_DW +: DAT_DW])
        );
    end

    assign result.valid = s3_valid_q;
    assign result.data  = z_all;
    assign out_last     = s3_last_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
